// File: rtl/lbm_step_sequencer_pkg.sv
// rtl/lbm_step_sequencer_pkg.sv - cell op encodings, run-controller states and state helpers
// State encoding widens to 4 bits when SINGLE_STEP_EN adds the PAUSE state.
package lbm_step_sequencer_pkg;

    localparam logic [1:0] OP_INIT    = 2'd0;
    localparam logic [1:0] OP_COLLIDE = 2'd1;
    localparam logic [1:0] OP_STREAM  = 2'd2;

`ifdef SINGLE_STEP_EN
    typedef enum logic [3:0] {
        ST_IDLE, ST_INIT, ST_INIT_DR, ST_COL, ST_COL_DR, ST_STR, ST_STR_DR, ST_DONE, ST_PAUSE
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_INIT, ST_INIT_DR, ST_COL, ST_COL_DR, ST_STR, ST_STR_DR, ST_DONE
    } state_t;
`endif

    function automatic logic is_drain(input state_t s);
        return (s == ST_INIT_DR) || (s == ST_COL_DR) || (s == ST_STR_DR);
    endfunction

    function automatic state_t drain_of(input state_t s);
        case (s)
            ST_INIT: return ST_INIT_DR;
            ST_COL:  return ST_COL_DR;
            default: return ST_STR_DR;
        endcase
    endfunction

endpackage

// File: rtl/lbm_step_sequencer_cell_scan_counter.sv
// rtl/lbm_step_sequencer_cell_scan_counter.sv - raster x/y cell counter, wraps to (0,0) after the last cell
module cell_scan_counter #(
    parameter int GRID_W = 64,
    parameter int GRID_H = 32,
    parameter int X_W    = 6,
    parameter int Y_W    = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           adv,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    localparam logic [X_W-1:0] X_LAST = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(GRID_H - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (adv) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/lbm_step_sequencer.sv
// rtl/lbm_step_sequencer.sv - LBM run controller: INIT sweep, then n_steps COLLIDE/STREAM timesteps
// SINGLE_STEP_EN adds input step_req and a PAUSE state between timesteps.
module lbm_step_sequencer #(
    parameter int GRID_W    = 64,
    parameter int GRID_H    = 32,
    parameter int X_W       = 6,
    parameter int Y_W       = 5,
    parameter int STEP_W    = 16,
    parameter int DRAIN_MIN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] n_steps,
`ifdef SINGLE_STEP_EN
    input  logic              step_req,
`endif
    output logic              cell_valid,
    input  logic              cell_ready,
    output logic [X_W-1:0]    cell_x,
    output logic [Y_W-1:0]    cell_y,
    output logic [1:0]        cell_op,
    input  logic              dp_busy,
    output logic              bank_sel,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [STEP_W-1:0] step_count
);

    import lbm_step_sequencer_pkg::*;

    localparam int DR_W = $clog2(DRAIN_MIN + 1) + 1;
    localparam logic [DR_W-1:0] DR_LAST = (DRAIN_MIN > 1) ? DR_W'(DRAIN_MIN - 1) : '0;

    state_t            state_q;
    logic              cell_valid_q, busy_q, done_q, aborted_q, bank_q;
    logic [1:0]        cell_op_q;
    logic [STEP_W-1:0] step_q, n_lat_q, step_inc;
    logic [DR_W-1:0]   drain_q;
    logic              fire, scan_last, scan_clr, drain_met, drain_exit;

    assign fire       = cell_valid_q & cell_ready;
    assign step_inc   = step_q + 1'b1;
    assign drain_met  = (drain_q >= DR_LAST);
    assign drain_exit = drain_met & ~dp_busy;
    // Every new run and every abort restarts the raster at (0,0); clr beats adv in the counter.
    assign scan_clr   = (state_q == ST_IDLE) ? start : abort;

    cell_scan_counter #(
        .GRID_W(GRID_W),
        .GRID_H(GRID_H),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_scan (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (scan_clr),
        .adv  (fire),
        .x    (cell_x),
        .y    (cell_y),
        .last (scan_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cell_valid_q <= 1'b0;
            cell_op_q    <= OP_INIT;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            bank_q       <= 1'b0;
            step_q       <= '0;
            n_lat_q      <= '0;
            drain_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (is_drain(state_q) && !drain_met) begin
                drain_q <= drain_q + 1'b1;
            end
            if (state_q != ST_IDLE && abort) begin
                state_q      <= ST_IDLE;
                cell_valid_q <= 1'b0;
                busy_q       <= 1'b0;
                aborted_q    <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q      <= ST_INIT;
                            cell_valid_q <= 1'b1;
                            cell_op_q    <= OP_INIT;
                            busy_q       <= 1'b1;
                            aborted_q    <= 1'b0;
                            bank_q       <= 1'b0;
                            step_q       <= '0;
                            n_lat_q      <= n_steps;
                        end
                    end
                    ST_INIT, ST_COL, ST_STR: begin
                        if (fire && scan_last) begin
                            state_q      <= drain_of(state_q);
                            cell_valid_q <= 1'b0;
                            drain_q      <= '0;
                        end
                    end
                    ST_INIT_DR: begin
                        if (drain_exit) begin
                            if (n_lat_q == '0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q      <= ST_COL;
                                cell_valid_q <= 1'b1;
                                cell_op_q    <= OP_COLLIDE;
                            end
                        end
                    end
                    ST_COL_DR: begin
                        if (drain_exit) begin
                            state_q      <= ST_STR;
                            cell_valid_q <= 1'b1;
                            cell_op_q    <= OP_STREAM;
                        end
                    end
                    ST_STR_DR: begin
                        if (drain_exit) begin
                            step_q <= step_inc;
                            bank_q <= ~bank_q;
                            if (step_inc == n_lat_q) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
`ifdef SINGLE_STEP_EN
                                state_q <= ST_PAUSE;
`else
                                state_q      <= ST_COL;
                                cell_valid_q <= 1'b1;
                                cell_op_q    <= OP_COLLIDE;
`endif
                            end
                        end
                    end
`ifdef SINGLE_STEP_EN
                    ST_PAUSE: begin
                        if (step_req) begin
                            state_q      <= ST_COL;
                            cell_valid_q <= 1'b1;
                            cell_op_q    <= OP_COLLIDE;
                        end
                    end
`endif
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q      <= ST_IDLE;
                        cell_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cell_valid = cell_valid_q;
    assign cell_op    = cell_op_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign bank_sel   = bank_q;
    assign step_count = step_q;

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// tb/tb_lbm_step_sequencer.sv - directed/random bench for lbm_step_sequencer on a 4x2 lattice
module tb_lbm_step_sequencer;

    localparam int GW = 4;
    localparam int GH = 2;
    localparam int XW = 2;
    localparam int YW = 1;
    localparam int SW = 16;
    localparam int DM = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          dp_busy = 1'b0;
    logic          cell_ready = 1'b1;
    logic [SW-1:0] n_steps = '0;
    logic          cell_valid, bank_sel, busy, done, aborted;
    logic [XW-1:0] cell_x;
    logic [YW-1:0] cell_y;
    logic [1:0]    cell_op;
    logic [SW-1:0] step_count;
`ifdef SINGLE_STEP_EN
    logic          step_req = 1'b1;
`endif

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;
    int done_cnt = 0;
    int stall_err = 0;
    logic [4:0] fq[$];
    logic [4:0] exp_q[$];
    logic       stall_prev = 1'b0;
    logic [4:0] stall_val = '0;

`define CHK(tag, obs, expv) \
    begin \
        checks++; \
        assert ((obs) === (expv)) else begin \
            errors++; \
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv); \
        end \
    end

    always #5 clk = ~clk;

    lbm_step_sequencer #(
        .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .STEP_W(SW), .DRAIN_MIN(DM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .n_steps   (n_steps),
`ifdef SINGLE_STEP_EN
        .step_req  (step_req),
`endif
        .cell_valid(cell_valid),
        .cell_ready(cell_ready),
        .cell_x    (cell_x),
        .cell_y    (cell_y),
        .cell_op   (cell_op),
        .dp_busy   (dp_busy),
        .bank_sel  (bank_sel),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .step_count(step_count)
    );

    always begin
        @(posedge clk);
        #1;
        cell_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Observe the handshake between edges: record fires, hold-under-stall and done pulses.
    always @(negedge clk) begin
        if (stall_prev && !(cell_valid === 1'b1 && {cell_op, cell_y, cell_x} === stall_val))
            stall_err++;
        if (cell_valid === 1'b1 && cell_ready === 1'b1)
            fq.push_back({cell_op, cell_y, cell_x});
        if (done === 1'b1)
            done_cnt++;
        stall_prev = rst_n && cell_valid === 1'b1 && cell_ready === 1'b0;
        stall_val  = {cell_op, cell_y, cell_x};
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference fire stream: INIT sweep, then COLLIDE/STREAM per step, each a full raster.
    task automatic build_exp(input int n);
        exp_q.delete();
        for (int s = 0; s <= 2 * n; s++) begin
            int op;
            op = (s == 0) ? 0 : ((s % 2 == 1) ? 1 : 2);
            for (int yy = 0; yy < GH; yy++)
                for (int xx = 0; xx < GW; xx++)
                    exp_q.push_back({2'(op), YW'(yy), XW'(xx)});
        end
    endtask

    task automatic cmp_fires(input string tag);
        int bad;
        string t;
        bad = -1;
        t = {tag, "_fire_count"};
        `CHK(t, fq.size(), exp_q.size())
        for (int i = 0; i < fq.size() && i < exp_q.size(); i++)
            if (bad < 0 && fq[i] !== exp_q[i]) bad = i;
        t = {tag, "_first_bad_fire_index"};
        `CHK(t, bad, -1)
    endtask

    task automatic do_start(input string tag, input int n);
        string t;
        fq.delete();
        n_steps = SW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        t = {tag, "_latency_valid"};
        `CHK(t, cell_valid, 1'b1)
        t = {tag, "_first_cell"};
        `CHK(t, {cell_op, cell_y, cell_x}, 5'd0)
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0, i;
        string t;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < budget) begin
            tick();
            i++;
        end
        tick();
        tick();
        t = {tag, "_done_pulses"};
        `CHK(t, done_cnt, d0 + 1)
        t = {tag, "_idle_busy"};
        `CHK(t, busy, 1'b0)
    endtask

    initial begin
        int d0, saw;
        string t;

        // Reset state
        repeat (3) tick();
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_valid", cell_valid, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_aborted", aborted, 1'b0)
        `CHK("rst_bank", bank_sel, 1'b0)
        `CHK("rst_step", step_count, 16'd0)
        `CHK("rst_cell", {cell_op, cell_y, cell_x}, 5'd0)
        rst_n = 1'b1;
        tick();

        // One timestep, always-ready datapath
        do_start("n1", 1);
        wait_done("n1", 500);
        build_exp(1);
        cmp_fires("n1");
        `CHK("n1_step", step_count, 16'd1)
        `CHK("n1_bank", bank_sel, 1'b1)

        // Zero timesteps: INIT only
        do_start("n0", 0);
        wait_done("n0", 500);
        build_exp(0);
        cmp_fires("n0");
        `CHK("n0_step", step_count, 16'd0)
        `CHK("n0_bank", bank_sel, 1'b0)

        // Random backpressure
        stall_err = 0;
        ready_mode = 1;
        do_start("rnd", 2);
        wait_done("rnd", 3000);
        ready_mode = 0;
        build_exp(2);
        cmp_fires("rnd");
        `CHK("rnd_stall_hold", stall_err, 0)
        `CHK("rnd_step", step_count, 16'd2)
        `CHK("rnd_bank", bank_sel, 1'b0)

        // Datapath busy holds the INIT drain
        dp_busy = 1'b1;
        do_start("drn", 1);
        for (int i = 0; i < 200 && fq.size() < GW * GH; i++) tick();
        `CHK("drn_init_fires", fq.size(), GW * GH)
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cell_valid !== 1'b0) saw++;
        end
        `CHK("drn_valid_while_busy", saw, 0)
        dp_busy = 1'b0;
        for (int i = 0; i < 20 && cell_valid !== 1'b1; i++) tick();
        `CHK("drn_col_start", {cell_valid, cell_op, cell_y, cell_x}, 6'b1_01_0_00)
        wait_done("drn", 500);
        build_exp(1);
        cmp_fires("drn");

        // Abort during COLLIDE at (2,0)
        d0 = done_cnt;
        do_start("abt", 3);
        for (int i = 0; i < 200 && !(cell_valid === 1'b1 && cell_op === 2'd1
                                    && cell_x === 2'd2 && cell_y === 1'b0); i++) tick();
        `CHK("abt_found_cell", {cell_valid, cell_op, cell_y, cell_x}, 6'b1_01_0_10)
        abort = 1'b1;
        tick();
        abort = 1'b0;
        `CHK("abt_busy", busy, 1'b0)
        `CHK("abt_valid", cell_valid, 1'b0)
        `CHK("abt_aborted", aborted, 1'b1)
        `CHK("abt_step", step_count, 16'd0)
        repeat (5) tick();
        `CHK("abt_no_done", done_cnt, d0)
        `CHK("abt_sticky", aborted, 1'b1)
        build_exp(3);
        while (exp_q.size() > GW * GH + 3) void'(exp_q.pop_back());
        cmp_fires("abt");

        // Start and abort together in IDLE: start wins, aborted clears
        fq.delete();
        n_steps = SW'(1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        `CHK("sa_busy", busy, 1'b1)
        `CHK("sa_aborted", aborted, 1'b0)
        `CHK("sa_bank", bank_sel, 1'b0)
        `CHK("sa_first", {cell_valid, cell_op, cell_y, cell_x}, 6'b1_00_0_00)
        wait_done("sa", 500);
        build_exp(1);
        cmp_fires("sa");
        `CHK("sa_bank_end", bank_sel, 1'b1)

        // start while busy is ignored and does not re-latch n_steps
        do_start("mid", 2);
        repeat (20) tick();
        n_steps = SW'(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("mid", 1000);
        build_exp(2);
        cmp_fires("mid");
        `CHK("mid_step", step_count, 16'd2)

        // Reset mid-run after one completed step
        d0 = done_cnt;
        do_start("mrst", 3);
        for (int i = 0; i < 500 && step_count !== 16'd1; i++) tick();
        `CHK("mrst_step_before", step_count, 16'd1)
        `CHK("mrst_bank_before", bank_sel, 1'b1)
        rst_n = 1'b0;
        tick();
        `CHK("mrst_busy", busy, 1'b0)
        `CHK("mrst_valid", cell_valid, 1'b0)
        `CHK("mrst_bank", bank_sel, 1'b0)
        `CHK("mrst_step", step_count, 16'd0)
        rst_n = 1'b1;
        repeat (3) tick();
        `CHK("mrst_no_done", done_cnt, d0)
        `CHK("mrst_idle", busy, 1'b0)

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
